// File: rtl/gat_load_scheduler_pkg.sv
// Shared types for the GAT load scheduler: FSM states, region select and region order.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package gat_load_scheduler_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_H,
        LD_INFO,
        LD_WGT,
        LD_SUB,
        WAIT_GAT,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD,
        FINISH
    } state_t;

    // Region select doubles as the bit position in the one-hot bram_ena {sub, wgt, info, h}.
    typedef enum logic [1:0] {
        REG_H    = 2'd0,
        REG_INFO = 2'd1,
        REG_WGT  = 2'd2,
        REG_SUB  = 2'd3
    } region_t;

    function automatic logic [3:0] region_ena(input region_t r);
        return 4'b0001 << r;
    endfunction

    function automatic region_t state_region(input state_t s);
        case (s)
            LD_INFO: return REG_INFO;
            LD_WGT:  return REG_WGT;
            LD_SUB:  return REG_SUB;
            default: return REG_H;
        endcase
    endfunction

    // Load order: h, info, wgt, sub, then wait for the accelerator.
    function automatic state_t next_load_state(input state_t s);
        case (s)
            LD_H:    return LD_INFO;
            LD_INFO: return LD_WGT;
            LD_WGT:  return LD_SUB;
            default: return WAIT_GAT;
        endcase
    endfunction

endpackage

// File: rtl/gat_load_scheduler_feat_reader.sv
// Feature readback: fetches cfg_len_feat words from the feature BRAM and streams them out.
// Latency: 1 issue + RD_LATENCY wait cycles per word before m_valid.
// Backpressure: m_data/m_last held stable in RD_HOLD until m_ready.
// Ports: state from the top FSM; feat_bram_addrb/feat_bram_dout BRAM read port;
//        m_valid/m_ready/m_data/m_last result stream; wait_done tells the FSM data is captured.
module gat_feat_reader
    import gat_load_scheduler_pkg::*;
#(
    parameter int LEN_W       = 19,
    parameter int BRAM_ADDR_W = 20,
    parameter int RD_LATENCY  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  state_t                 state,
    input  logic [LEN_W-1:0]       len_feat,
    output logic [BRAM_ADDR_W-1:0] feat_bram_addrb,
    input  logic [31:0]            feat_bram_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic                   m_last,
    output logic                   wait_done
);

    localparam int WC_W = $clog2(RD_LATENCY + 1);

    logic [LEN_W-1:0] idx;
    logic [WC_W-1:0]  wait_cnt;
    logic             in_rd;

    always_comb begin
        in_rd           = state inside {RD_ISSUE, RD_WAIT, RD_HOLD};
        // Address stays on the port through the wait so any BRAM latency sees a stable request.
        feat_bram_addrb = in_rd ? BRAM_ADDR_W'({idx, 2'b00}) : '0;
        wait_done       = (state == RD_WAIT) && (wait_cnt == WC_W'(RD_LATENCY - 1));
        m_valid         = (state == RD_HOLD);
        m_last          = m_valid && (idx == len_feat - LEN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            wait_cnt <= '0;
            m_data   <= '0;
        end else begin
            case (state)
                WAIT_GAT: begin
                    idx      <= '0;
                    wait_cnt <= '0;
                end
                RD_ISSUE: wait_cnt <= '0;
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + WC_W'(1);
                    if (wait_done) m_data <= feat_bram_dout;
                end
                RD_HOLD: if (m_ready) idx <= idx + LEN_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gat_load_scheduler.sv
// GAT job scheduler: loads h/info/wgt/sub regions from a stream, waits for the accelerator, reads features back.
// Latency: BRAM write combinational with the s_valid/s_ready handshake; readback 1+RD_LATENCY cycles per word.
// Backpressure: s_ready only in load states; result stream stalls on m_ready.
// Ports: start + cfg_len_* job setup; s_* load stream; bram_* shared write port; *_load_done region levels;
//        gat_ready accelerator completion; feat_bram_* readback port; m_* result stream; busy/done/compute_cycles status.
module gat_load_scheduler
    import gat_load_scheduler_pkg::*;
#(
    parameter int TOP_WIDTH   = 32,
    parameter int BRAM_ADDR_W = 20,
    parameter int LEN_W       = 19,
    parameter int RD_LATENCY  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       cfg_len_h,
    input  logic [LEN_W-1:0]       cfg_len_info,
    input  logic [LEN_W-1:0]       cfg_len_wgt,
    input  logic [LEN_W-1:0]       cfg_len_sub,
    input  logic [LEN_W-1:0]       cfg_len_feat,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [TOP_WIDTH-1:0]   s_data,
    output logic [TOP_WIDTH-1:0]   bram_din,
    output logic                   bram_wea,
    output logic [BRAM_ADDR_W-1:0] bram_addra,
    output logic [3:0]             bram_ena,
    output logic                   h_data_bram_load_done,
    output logic                   h_node_info_bram_load_done,
    output logic                   wgt_bram_load_done,
    input  logic                   gat_ready,
    output logic [BRAM_ADDR_W-1:0] feat_bram_addrb,
    input  logic [31:0]            feat_bram_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            compute_cycles
);

    state_t           state, state_nxt;
    region_t          region;
    logic [LEN_W-1:0] len_h, len_info, len_wgt, len_sub, len_feat;
    logic [LEN_W-1:0] cnt, cur_len;
    logic             in_ld, s_hs, region_end, gat_q, gat_rise, wait_done;

    always_comb begin
        in_ld  = state inside {LD_H, LD_INFO, LD_WGT, LD_SUB};
        region = state_region(state);
        case (region)
            REG_H:    cur_len = len_h;
            REG_INFO: cur_len = len_info;
            REG_WGT:  cur_len = len_wgt;
            default:  cur_len = len_sub;
        endcase
        // A zero-length region never raises s_ready, so it is skipped in one cycle with no writes.
        s_ready    = in_ld && (cur_len != '0);
        s_hs       = s_valid && s_ready;
        region_end = in_ld && ((cur_len == '0) || (s_hs && (cnt == cur_len - LEN_W'(1))));
        gat_rise   = gat_ready && !gat_q;

        bram_wea   = s_hs;
        bram_ena   = s_hs ? region_ena(region) : 4'b0000;
        bram_din   = s_hs ? s_data : '0;
        bram_addra = s_hs ? BRAM_ADDR_W'({cnt, 2'b00}) : '0;

        busy = (state != IDLE);
        done = (state == FINISH);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = LD_H;
            LD_H, LD_INFO, LD_WGT, LD_SUB:
                      if (region_end) state_nxt = next_load_state(state);
            WAIT_GAT: if (gat_rise) state_nxt = (len_feat == '0) ? FINISH : RD_ISSUE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (wait_done) state_nxt = RD_HOLD;
            RD_HOLD:  if (m_valid && m_ready) state_nxt = m_last ? FINISH : RD_ISSUE;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_h                      <= '0;
            len_info                   <= '0;
            len_wgt                    <= '0;
            len_sub                    <= '0;
            len_feat                   <= '0;
            cnt                        <= '0;
            gat_q                      <= 1'b0;
            compute_cycles             <= '0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
        end else begin
            gat_q <= gat_ready;
            if (state == IDLE && start) begin
                len_h                      <= cfg_len_h;
                len_info                   <= cfg_len_info;
                len_wgt                    <= cfg_len_wgt;
                len_sub                    <= cfg_len_sub;
                len_feat                   <= cfg_len_feat;
                cnt                        <= '0;
                compute_cycles             <= '0;
                h_data_bram_load_done      <= 1'b0;
                h_node_info_bram_load_done <= 1'b0;
                wgt_bram_load_done         <= 1'b0;
            end
            if (region_end) begin
                cnt <= '0;
                case (region)
                    REG_H:    h_data_bram_load_done      <= 1'b1;
                    REG_INFO: h_node_info_bram_load_done <= 1'b1;
                    REG_WGT:  wgt_bram_load_done         <= 1'b1;
                    default:  ;
                endcase
            end else if (s_hs) begin
                cnt <= cnt + LEN_W'(1);
            end
            if (state == WAIT_GAT) compute_cycles <= compute_cycles + 32'd1;
        end
    end

    gat_feat_reader #(
        .LEN_W       (LEN_W),
        .BRAM_ADDR_W (BRAM_ADDR_W),
        .RD_LATENCY  (RD_LATENCY)
    ) u_feat_reader (
        .clk             (clk),
        .rst             (rst),
        .state           (state),
        .len_feat        (len_feat),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .wait_done       (wait_done)
    );

endmodule

// File: doc/gat_load_scheduler.md
GAT_LOAD_SCHEDULER -- requirements
Module: gat_load_scheduler

Interface
REQ-001 Parameter TOP_WIDTH, default 32, width of the bus word.
REQ-002 Parameter BRAM_ADDR_W, default 20, byte-address width of the shared write port (covers the largest region, 18+2).
REQ-003 Parameter LEN_W, default 19, width of the word-count configuration inputs.
REQ-004 Parameter RD_LATENCY, default 2, feature BRAM read latency in cycles.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle job start.
REQ-008 cfg_len_h, cfg_len_info, cfg_len_wgt, cfg_len_sub, cfg_len_feat  in  LEN_W each  word counts per region; sampled on accepted start.
REQ-009 s_valid / s_ready / s_data  in / out / in TOP_WIDTH  load stream, one word per handshake.
REQ-010 bram_din  out  TOP_WIDTH; bram_wea  out  1; bram_addra  out  BRAM_ADDR_W (byte address = word index x4); bram_ena  out  4 one-hot {sub, wgt, info, h}.
REQ-011 h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1 each  region-complete levels.
REQ-012 gat_ready  in  1  accelerator completion.
REQ-013 feat_bram_addrb  out  BRAM_ADDR_W byte address; feat_bram_dout  in  32.
REQ-014 m_valid / m_ready / m_data / m_last  out / in / out 32 / out  result stream.
REQ-015 busy  out 1; done  out 1 (one-cycle pulse); compute_cycles  out 32.

Function
REQ-016 States IDLE, LD_H, LD_INFO, LD_WGT, LD_SUB, WAIT_GAT, RD_ISSUE, RD_WAIT, RD_HOLD, FINISH.
REQ-017 start in IDLE latches all cfg_len_* and clears load_done flags, compute_cycles, and word counter; next state LD_H; start outside IDLE is ignored.
REQ-018 In LD_* states s_ready = 1; each s_valid&&s_ready cycle drives bram_din=s_data, bram_wea=1, that region's bram_ena bit, bram_addra=counter<<2 combinationally in the same cycle, then increments counter.
REQ-019 When the counter reaches the region length, the region flag (if any) sets on the next edge and stays set until next accepted start; counter resets; advance to the next region in order h, info, wgt, sub, then WAIT_GAT.
REQ-020 A region with length 0 is skipped in one cycle with its flag set and no writes.
REQ-021 Outside LD_* states s_ready = 0, bram_ena = 0, bram_wea = 0.
REQ-022 WAIT_GAT: compute_cycles increments every cycle; exit on rising edge of gat_ready (registered previous value) detected in WAIT_GAT; a level already high on entry does not exit.
REQ-023 Readback: RD_ISSUE drives feat_bram_addrb=idx<<2; RD_WAIT counts RD_LATENCY cycles; RD_HOLD registers feat_bram_dout into m_data with m_valid=1, holding m_data stable until m_ready.
REQ-024 m_last = 1 with the word idx = cfg_len_feat-1; after its handshake go to FINISH; cfg_len_feat = 0 goes directly to FINISH.
REQ-025 FINISH pulses done for one cycle, returns to IDLE; load_done flags and compute_cycles hold their values.
REQ-026 busy = 1 in every state except IDLE.
REQ-027 Counters saturate never; compute_cycles wraps modulo 2^32.

Reset
REQ-028 rst in any state forces IDLE on the next edge; all outputs 0, all counters and flags 0, including mid-load and mid-readback.

Structure
REQ-029 State enum, region-select encoding, and region order belong in the shared GAT package.
REQ-030 One sub-module, gat_feat_reader, implements REQ-023/024; the rest is flat.

Verification
REQ-031 Lengths h=3, info=2, wgt=2, sub=1, feat=2: 8 words streamed back-to-back -> addra 0,4,8 / 0,4 / 0,4 / 0 with matching ena bits, flags rise after words 3, 5, 7.
REQ-032 s_valid toggled every other cycle -> no missed or duplicated writes; addresses contiguous.
REQ-033 gat_ready high on WAIT_GAT entry, low 5 cycles, then high -> exit on rising edge, compute_cycles reflects the elapsed cycles (not exiting on the initial high level).
REQ-034 feat=3, m_ready low 4 cycles on word 1 -> m_data stable, m_last only on word 2, done one cycle later.
REQ-035 cfg_len_wgt=0 -> wgt_bram_load_done set with zero wgt writes.
REQ-036 rst asserted mid LD_INFO, then start -> all flags 0, restart at h address 0.
